// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop rx synchronizer; majority-of-3 sampling under UART_RX_MAJORITY_EN.
// Latency: rx_val/frame_err pulse one clk after the stop-bit sample decision.
// Backpressure: none; rx_data is overwritten by each valid frame.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       pulse_rx,
    output logic [7:0] rx_data,
    output logic       rx_val,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the tick after centre, so every decision lands one tick late.
    localparam int START_DEC = HALF + 1;
`else
    localparam int START_DEC = HALF;
`endif
    localparam logic [CW-1:0] START_LAST = CW'(START_DEC - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            val_q, val_d;
    logic            err_q, err_d;
    logic            rx_s;
    logic            sample;

    assign sync_d = {sync_q[0], rx};
    assign rx_s   = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q, vote_d;

    assign vote_d = pulse_rx ? {vote_q[0], rx_s} : vote_q;
    assign sample = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vote_q <= 2'b11;
        else     vote_q <= vote_d;
    end
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        val_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (pulse_rx) begin
                    if (cnt_q == START_LAST) begin
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                        state_d = sample ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                if (pulse_rx) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {sample, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            STOP: begin
                if (pulse_rx) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d = '0;
                        if (sample) begin
                            data_d  = shift_q;
                            val_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_val    = val_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);
endmodule
